cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Run/step/halt controller for the single-cycle RISC-V core. It runs entirely in the board clock domain and drives a one-cycle clock-enable pulse (`cpu_en`) that qualifies every architectural state update in the core. In free-run mode it issues enables at a programmable divided rate. In step mode it issues exactly one enable per debounced press of a board push-button. Replaces gating or dividing the generated CPU clock; all core registers stay on one clock.

## Interface
Parameters:
- `DIV_W`, 24: width of divider reload value `div_i`.
- `DEB_LIMIT`, 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); minimum 1.

Ports:
- `clk_i`  in  1  board clock; single clock of the block.
- `rst_i`  in  1  synchronous, active-high reset.
- `mode_run`  in  1  1 = free-run, 0 = single-step; synchronous level.
- `halt_i`  in  1  1 = suppress all enables; synchronous level, highest priority.
- `div_i`  in  DIV_W  enable period minus one (0 = enable every cycle).
- `step_btn`  in  1  raw asynchronous push-button, active-high.
- `cpu_en`  out  1  registered one-cycle enable pulse to the core.
- `cycle_cnt`  out  32  number of `cpu_en` pulses issued since reset.
- `state_o`  out  2  current FSM state (debug LEDs).

## Operation
- Button path:
  - Two-flop synchronizer produces `s2`.
  - Debouncer holds a level `db` and a counter. The counter increments while `s2 != db` and clears while `s2 == db`.
  - On the `DEB_LIMIT`-th consecutive mismatch cycle, `db <= s2` and the counter clears.
  - `step_req` is asserted for one cycle on a 0->1 transition of `db`. Release needs the same debouncing but generates nothing.
- FSM states and encodings: `HALT`=0, `STEP`=1, `RUN`=2.
- State selection, evaluated every cycle with priority in this order:
  - `halt_i`=1 -> `HALT`.
  - else `mode_run`=1 -> `RUN`.
  - else -> `STEP`.
- Divider counter `dcnt` (`DIV_W` bits):
  - Counts only in `RUN`.
  - When `dcnt >= div_i`, the block pulses `cpu_en` and sets `dcnt <= 0`; otherwise `dcnt <= dcnt+1`.
  - The `>=` comparison makes a mid-count decrease of `div_i` take effect without overflow.
  - In `HALT`, `dcnt` holds its value. On any transition into `STEP`, `dcnt` clears.
- `STEP`: `cpu_en` is asserted for exactly one cycle per `step_req`.
- `step_req` handling:
  - Ignored in `RUN` and `HALT`; it is not queued.
  - The debouncer keeps running in every state.
- `cycle_cnt` increments by 1 on each cycle `cpu_en`=1 and wraps modulo 2^32.
- Reset values: `cpu_en`=0, `cycle_cnt`=0, `state_o`=`HALT`, `dcnt`=0, `db`=0, synchronizer flops=0, debounce counter=0.
  - The first post-reset cycle re-evaluates the state from its inputs.
  - No enable is issued in the cycle following reset deassertion.
- Reset asserted mid-run or mid-debounce aborts immediately; a partially debounced press is lost.

## Timing
- `cpu_en`, `cycle_cnt`, `state_o` are registered.
- State changes take effect one cycle after the input changes.
- `RUN`, `div_i`=N constant: pulses are exactly N+1 cycles apart, one cycle wide. N=0 gives `cpu_en` continuously high; `cycle_cnt` increments every cycle.
- Entering `RUN` from `STEP`: first pulse occurs N+1 cycles after `state_o` shows `RUN` (`dcnt` starts at 0).
- Button timing, with the raw button rising before edge k and held:
  - `s2`=1 after edge k+1.
  - `db`=1 after edge k+1+`DEB_LIMIT`.
  - `cpu_en`=1 for the cycle following edge k+2+`DEB_LIMIT`.
- Glitches shorter than `DEB_LIMIT` cycles (after synchronization) produce no pulse.
- `halt_i` rising: no `cpu_en` from the cycle after the state register shows `HALT`. A pulse already registered in the same edge completes; at most one pulse overlaps.
- `halt_i` and `step_req` in the same cycle: no pulse.
- `cycle_cnt` at 0xFFFFFFFF plus one pulse -> 0x00000000.

## Test plan
All scenarios use `DEB_LIMIT`=4, `DIV_W`=8.
- Reset then `mode_run`=1, `div_i`=3 for 40 cycles -> `cpu_en` high 1 of every 4 cycles, first pulse 4 cycles after `state_o`=2, `cycle_cnt`=10 at end.
- `RUN`, `div_i`=9 with `dcnt` at 7, change `div_i` to 2 -> pulse on next cycle (7>=2), then every 3 cycles.
- `STEP`, `step_btn` rises before edge k and is held for 20 cycles -> single `cpu_en` in cycle after edge k+6, `cycle_cnt` 0->1. Release -> no pulse.
- `STEP`, `step_btn` glitch high for 3 cycles, then 5 bounces of 1-2 cycles -> no `cpu_en`, `cycle_cnt` unchanged.
- `RUN`, `div_i`=0, assert `halt_i` for 10 cycles -> `cpu_en` drops after ≤1 overlap cycle, `state_o`=0, `dcnt` held. Press during `HALT` -> no pulse. Deassert -> pulses resume next cycle.
- Force `cycle_cnt` near wrap (0xFFFFFFFE), `div_i`=0, `RUN` -> counts FFFFFFFF, 0, 1. Assert `rst_i` mid-sequence -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller: issues a one-cycle clock enable to the core, either at a
// programmable divided rate (free-run) or once per debounced push-button press (step).
module cpu_clk_ctrl #(
    parameter int DIV_W     = 24,
    parameter int DEB_LIMIT = 1000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mode_run,
    input  logic             halt_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             step_btn,
    output logic             cpu_en,
    output logic [31:0]      cycle_cnt,
    output logic [1:0]       state_o
);

    localparam int CNT_W = (DEB_LIMIT > 1) ? $clog2(DEB_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LIMIT - 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic             sync1_r;
    logic             s2_r;
    logic             db_r;
    logic             db_d_r;
    logic [CNT_W-1:0] deb_cnt_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [DIV_W-1:0] dcnt_r;
    logic             step_req_s;
    logic             fire_s;

    // Two-flop synchronizer for the raw push-button
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= 1'b0;
            s2_r    <= 1'b0;
        end else begin
            sync1_r <= step_btn;
            s2_r    <= sync1_r;
        end
    end

    // Debouncer: accept a new level only after DEB_LIMIT consecutive mismatching cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            db_r      <= 1'b0;
            db_d_r    <= 1'b0;
            deb_cnt_r <= {CNT_W{1'b0}};
        end else begin
            db_d_r <= db_r;
            if (s2_r != db_r) begin
                if (deb_cnt_r == CNT_LAST) begin
                    db_r      <= s2_r;
                    deb_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    deb_cnt_r <= deb_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                deb_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Next-state selection and enable decision; halt_i overrides any pending enable
    always_comb begin
        state_nxt_s = HALT;
        step_req_s  = db_r & ~db_d_r;
        fire_s      = 1'b0;
        if (halt_i) begin
            state_nxt_s = HALT;
        end else if (mode_run) begin
            state_nxt_s = RUN;
        end else begin
            state_nxt_s = STEP;
        end
        if (halt_i) begin
            fire_s = 1'b0;
        end else begin
            case (state_r)
                RUN:     fire_s = (dcnt_r >= div_i);
                STEP:    fire_s = step_req_s;
                HALT:    fire_s = 1'b0;
                default: fire_s = 1'b0;
            endcase
        end
    end

    // FSM, divider counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= HALT;
            dcnt_r    <= {DIV_W{1'b0}};
            cpu_en    <= 1'b0;
            cycle_cnt <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            cpu_en  <= fire_s;
            if (fire_s) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end else begin
                cycle_cnt <= cycle_cnt;
            end
            // The >= compare lets a lowered div_i take effect mid-count without wrapping
            case (state_r)
                RUN: begin
                    if (halt_i) begin
                        dcnt_r <= dcnt_r;
                    end else if (fire_s) begin
                        dcnt_r <= {DIV_W{1'b0}};
                    end else begin
                        dcnt_r <= dcnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                STEP:    dcnt_r <= {DIV_W{1'b0}};
                HALT:    dcnt_r <= dcnt_r;
                default: dcnt_r <= {DIV_W{1'b0}};
            endcase
        end
    end

    assign state_o = state_r;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: a cycle-level reference model pushes the expected
// outputs each clock edge and a separate monitor pops and compares on the falling edge.
module tb_cpu_clk_ctrl;

    localparam int DIV_W = 8;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             mode_run;
    logic             halt_i;
    logic [DIV_W-1:0] div_i;
    logic             step_btn;
    logic             cpu_en;
    logic [31:0]      cycle_cnt;
    logic [1:0]       state_o;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic        en;
        logic [31:0] cnt;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    bit   preload_req = 1'b0;

    always #5 clk = ~clk;

    cpu_clk_ctrl #(.DIV_W(DIV_W), .DEB_LIMIT(DEB)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .mode_run (mode_run),
        .halt_i   (halt_i),
        .div_i    (div_i),
        .step_btn (step_btn),
        .cpu_en   (cpu_en),
        .cycle_cnt(cycle_cnt),
        .state_o  (state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference model state (0=HALT, 1=STEP, 2=RUN); phase counts cycles since last pulse.
    logic [1:0]  btn_hist = 2'b00;
    logic        m_db     = 1'b0;
    int          m_run    = 0;
    logic        m_rose   = 1'b0;
    int          m_state  = 0;
    int          m_phase  = 0;
    logic [31:0] m_cnt    = 32'd0;

    always @(posedge clk) begin : model
        logic fire;
        logic req;
        logic s2_old;
        exp_t e;
        if (preload_req) m_cnt = 32'hFFFF_FFFE;
        fire = 1'b0;
        if (rst_i) begin
            btn_hist = 2'b00;
            m_db     = 1'b0;
            m_run    = 0;
            m_rose   = 1'b0;
            m_state  = 0;
            m_phase  = 0;
            m_cnt    = 32'd0;
        end else begin
            s2_old = btn_hist[1];
            req    = m_rose;
            m_rose = 1'b0;
            if (s2_old != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    m_db   = s2_old;
                    m_run  = 0;
                    m_rose = s2_old;
                end
            end else begin
                m_run = 0;
            end
            btn_hist = {btn_hist[0], step_btn};
            if (m_state == 1) m_phase = 0;
            if (!halt_i) begin
                if (m_state == 2) begin
                    if (m_phase >= int'(div_i)) begin
                        fire    = 1'b1;
                        m_phase = 0;
                    end else begin
                        m_phase++;
                    end
                end else if (m_state == 1) begin
                    fire = req;
                end
            end
            if (fire) m_cnt = m_cnt + 32'd1;
            m_state = halt_i ? 0 : (mode_run ? 2 : 1);
        end
        e.en  = fire;
        e.cnt = m_cnt;
        e.st  = 2'(m_state);
        exp_q.push_back(e);
    end

    // Monitor: one expected record per clock edge, compared on the falling edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("cpu_en", 32'(cpu_en), 32'(e.en));
            chk("cycle_cnt", cycle_cnt, e.cnt);
            chk("state_o", 32'(state_o), 32'(e.st));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int btn_left;
        rst_i    = 1'b1;
        mode_run = 1'b1;
        halt_i   = 1'b0;
        div_i    = 8'd3;
        step_btn = 1'b0;
        cyc(3);
        rst_i = 1'b0;
        cyc(42);

        // lower div_i while the divider is part-way through a long period
        mode_run = 1'b0;
        cyc(3);
        mode_run = 1'b1;
        div_i    = 8'd9;
        cyc(8);
        div_i = 8'd2;
        cyc(12);

        // clean press and release in step mode
        mode_run = 1'b0;
        div_i    = 8'd3;
        cyc(5);
        step_btn = 1'b1;
        cyc(20);
        step_btn = 1'b0;
        cyc(12);

        // glitch and short bounces
        step_btn = 1'b1;
        cyc(3);
        step_btn = 1'b0;
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            step_btn = 1'b1;
            cyc($urandom_range(2, 1));
            step_btn = 1'b0;
            cyc($urandom_range(2, 1));
        end
        cyc(10);

        // halt during continuous run, press while halted
        mode_run = 1'b1;
        div_i    = 8'd0;
        cyc(6);
        halt_i = 1'b1;
        cyc(4);
        step_btn = 1'b1;
        cyc(8);
        step_btn = 1'b0;
        cyc(8);
        halt_i = 1'b0;
        cyc(6);

        // counter wrap, then reset mid-sequence
        #2;
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        preload_req = 1'b1;
        #1;
        release dut.cycle_cnt;
        cyc(1);
        preload_req = 1'b0;
        cyc(2);
        rst_i = 1'b1;
        cyc(1);
        rst_i = 1'b0;
        cyc(4);

        // randomized mix of all inputs
        btn_left = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(39, 0) == 0) mode_run = ~mode_run;
            if ($urandom_range(59, 0) == 0) halt_i = ~halt_i;
            if ($urandom_range(49, 0) == 0) div_i = 8'($urandom_range(7, 0));
            if (btn_left == 0) begin
                step_btn = ~step_btn;
                btn_left = $urandom_range(12, 1);
            end else begin
                btn_left--;
            end
            rst_i = ($urandom_range(499, 0) == 0);
            cyc(1);
        end
        rst_i = 1'b0;
        cyc(2);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
